// File: rtl/local_flit_injector.sv
// rtl/local_flit_injector.sv - LOCAL-port traffic source: segments descriptors + payload into VC-tagged flits.
// Optional build macro LOCAL_INJECTOR_STATS_EN adds saturating flit/packet/stall counters.
package local_flit_injector_pkg;
  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE   = 16;
  localparam int HEAD_PAD_SIZE    = FLIT_DATA_SIZE - 2*DEST_ADDR_SIZE_X - 2*DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [HEAD_PAD_SIZE-1:0]    pad;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [DEST_ADDR_SIZE_X-1:0] x_source;
    logic [DEST_ADDR_SIZE_Y-1:0] y_source;
  } head_data_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;
endpackage

module local_flit_injector
  import local_flit_injector_pkg::*;
#(
  parameter int MAX_PKT_LEN = 16,
  parameter int X_CURRENT   = MESH_SIZE_X/2,
  parameter int Y_CURRENT   = MESH_SIZE_Y/2,
  parameter int LW          = $clog2(MAX_PKT_LEN+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
  input  logic [LW-1:0]               pkt_len_i,
  input  logic                        pld_valid_i,
  output logic                        pld_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]   pld_data_i,
  output flit_t                       data_o,
  output logic                        is_valid_o,
  input  logic [VC_NUM-1:0]           is_on_off_i,
  input  logic [VC_NUM-1:0]           is_allocatable_i,
`ifdef LOCAL_INJECTOR_STATS_EN
  output logic [31:0]                 flits_sent_o,
  output logic [31:0]                 pkts_sent_o,
  output logic [31:0]                 stall_cycles_o,
`endif
  output logic                        busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_VC_SEL, ST_HEAD, ST_BODY} state_t;

  state_t                      state_q, state_d;
  logic [DEST_ADDR_SIZE_X-1:0] x_dest_q, x_dest_d;
  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_q, y_dest_d;
  logic [LW-1:0]               len_q, len_d;
  logic [LW-1:0]               remaining_q, remaining_d;
  logic [VC_SIZE-1:0]          cur_vc_q, cur_vc_d;
  logic [VC_SIZE-1:0]          rr_ptr_q, rr_ptr_d;

  logic               sel_found;
  logic [VC_SIZE-1:0] sel_vc;
  logic               on_cur;
  head_data_t         head_data;

  assign on_cur = is_on_off_i[cur_vc_q];

  // Round-robin search: first allocatable VC at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (!sel_found && is_allocatable_i[(int'(rr_ptr_q) + i) % VC_NUM]) begin
        sel_found = 1'b1;
        sel_vc    = VC_SIZE'((int'(rr_ptr_q) + i) % VC_NUM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_dest_q    <= '0;
      y_dest_q    <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      cur_vc_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_dest_q    <= x_dest_d;
      y_dest_q    <= y_dest_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      cur_vc_q    <= cur_vc_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pkt_valid_i) state_d = ST_VC_SEL;
      ST_VC_SEL: if (sel_found) state_d = ST_HEAD;
      ST_HEAD:   if (on_cur) state_d = (len_q == LW'(1)) ? ST_IDLE : ST_BODY;
      ST_BODY:   if (on_cur && pld_valid_i && remaining_q == LW'(1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_dest_d    = x_dest_q;
    y_dest_d    = y_dest_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    cur_vc_d    = cur_vc_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: if (pkt_valid_i) begin
        x_dest_d = pkt_x_dest_i;
        y_dest_d = pkt_y_dest_i;
        len_d    = (pkt_len_i == '0) ? LW'(1) : pkt_len_i;
      end
      ST_VC_SEL: if (sel_found) begin
        cur_vc_d = sel_vc;
        rr_ptr_d = VC_SIZE'((int'(sel_vc) + 1) % VC_NUM);
      end
      ST_HEAD: if (on_cur) remaining_d = len_q - LW'(1);
      ST_BODY: if (on_cur && pld_valid_i) remaining_d = remaining_q - LW'(1);
      default: ;
    endcase
  end

  always_comb begin
    head_data          = '0;
    head_data.x_dest   = x_dest_q;
    head_data.y_dest   = y_dest_q;
    head_data.x_source = DEST_ADDR_SIZE_X'(X_CURRENT);
    head_data.y_source = DEST_ADDR_SIZE_Y'(Y_CURRENT);
  end

  always_comb begin
    pkt_ready_o = (state_q == ST_IDLE);
    pld_ready_o = (state_q == ST_BODY) && on_cur;
    busy_o      = (state_q != ST_IDLE);
    is_valid_o  = 1'b0;
    data_o      = '0;
    case (state_q)
      ST_HEAD: if (on_cur) begin
        is_valid_o        = 1'b1;
        data_o.flit_label = (len_q == LW'(1)) ? HEADTAIL : HEAD;
        data_o.vc_id      = cur_vc_q;
        data_o.data       = head_data;
      end
      ST_BODY: if (on_cur && pld_valid_i) begin
        is_valid_o        = 1'b1;
        data_o.flit_label = (remaining_q == LW'(1)) ? TAIL : BODY;
        data_o.vc_id      = cur_vc_q;
        data_o.data       = pld_data_i;
      end
      default: ;
    endcase
  end

`ifdef LOCAL_INJECTOR_STATS_EN
  logic [31:0] flits_q, pkts_q, stalls_q;
  logic        last_flit;

  assign last_flit = is_valid_o &&
                     (data_o.flit_label == TAIL || data_o.flit_label == HEADTAIL);

  always_ff @(posedge clk) begin
    if (rst) begin
      flits_q  <= '0;
      pkts_q   <= '0;
      stalls_q <= '0;
    end else begin
      if (is_valid_o && flits_q != '1) flits_q <= flits_q + 32'd1;
      if (last_flit && pkts_q != '1) pkts_q <= pkts_q + 32'd1;
      if (busy_o && !is_valid_o && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign flits_sent_o   = flits_q;
  assign pkts_sent_o    = pkts_q;
  assign stall_cycles_o = stalls_q;
`endif

endmodule

// File: tb/tb_local_flit_injector.sv
// tb/tb_local_flit_injector.sv - scoreboard bench for local_flit_injector.
// Driver pushes expected flits; a negedge monitor pops and compares each emitted flit.
`timescale 1ns/1ps
module tb_local_flit_injector;
  import local_flit_injector_pkg::*;

  localparam int LW = 5;

  typedef struct {
    flit_t f;
    int    cyc;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        pkt_valid_i = 1'b0;
  logic                        pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i = '0;
  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i = '0;
  logic [LW-1:0]               pkt_len_i = '0;
  logic                        pld_valid_i = 1'b0;
  logic                        pld_ready_o;
  logic [FLIT_DATA_SIZE-1:0]   pld_data_i = '0;
  flit_t                       data_o;
  logic                        is_valid_o;
  logic [VC_NUM-1:0]           is_on_off_i = '1;
  logic [VC_NUM-1:0]           is_allocatable_i = '1;
  logic                        busy_o;
`ifdef LOCAL_INJECTOR_STATS_EN
  logic [31:0]                 flits_sent_o, pkts_sent_o, stall_cycles_o;
`endif

  local_flit_injector dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .pkt_x_dest_i     (pkt_x_dest_i),
    .pkt_y_dest_i     (pkt_y_dest_i),
    .pkt_len_i        (pkt_len_i),
    .pld_valid_i      (pld_valid_i),
    .pld_ready_o      (pld_ready_o),
    .pld_data_i       (pld_data_i),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i),
`ifdef LOCAL_INJECTOR_STATS_EN
    .flits_sent_o     (flits_sent_o),
    .pkts_sent_o      (pkts_sent_o),
    .stall_cycles_o   (stall_cycles_o),
`endif
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  logic [FLIT_DATA_SIZE-1:0] pld_q[$];
  bit pld_fire = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input int vc, input logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.data       = d;
    return f;
  endfunction

  // Source coordinates are (2,2) for the default 4x4 mesh.
  function automatic logic [15:0] head_word(input int x, input int y);
    logic [1:0] xd, yd;
    xd = 2'(x);
    yd = 2'(y);
    return {8'h00, xd, yd, 2'd2, 2'd2};
  endfunction

  // Payload source: offers the queue head, pops after a sampled handshake.
  always @(negedge clk) pld_fire = pld_valid_i && pld_ready_o && !rst;
  always @(posedge clk) begin
    #2;
    if (pld_fire && pld_q.size() > 0) void'(pld_q.pop_front());
    pld_fire = 1'b0;
    if (pld_q.size() > 0) begin
      pld_valid_i = 1'b1;
      pld_data_i  = pld_q[0];
    end else begin
      pld_valid_i = 1'b0;
      pld_data_i  = '0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (is_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 64'(is_valid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("flit", 64'(data_o), 64'(e.f));
          if (e.cyc >= 0) check("flit_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("idle_data_zero", 64'(data_o), 64'd0);
      end
    end
  end

  // hd = expected HEAD cycle offset from the accept cycle, or -1 for no timing check.
  task automatic send_pkt(input int x, input int y, input int len, input int vc, input int hd,
                          input logic [15:0] base, output int acc);
    exp_t e;
    int n, eff;
    pkt_valid_i  = 1'b1;
    pkt_x_dest_i = 2'(x);
    pkt_y_dest_i = 2'(y);
    pkt_len_i    = LW'(len);
    n = 0;
    @(negedge clk);
    while (!pkt_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("desc_accept", 64'(pkt_ready_o), 64'd1);
    acc = cyc;
    eff = (len == 0) ? 1 : len;
    e.f   = mk((eff == 1) ? HEADTAIL : HEAD, vc, head_word(x, y));
    e.cyc = (hd < 0) ? -1 : acc + hd;
    exp_q.push_back(e);
    for (int k = 1; k < eff; k++) begin
      pld_q.push_back(base + 16'(k - 1));
      e.f   = mk((k == eff - 1) ? TAIL : BODY, vc, base + 16'(k - 1));
      e.cyc = (hd < 0) ? -1 : acc + hd + k;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pkt_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", 64'(busy_o), 64'd0);
    check("drain_expected_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_body();
    int n;
    n = 0;
    @(negedge clk);
    while (!(is_valid_o && data_o.flit_label == BODY) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("body_seen", 64'(is_valid_o), 64'd1);
  endtask

  initial begin
    int a1, a2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(is_valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
    check("rst_pld_ready", 64'(pld_ready_o), 64'd0);
`ifdef LOCAL_INJECTOR_STATS_EN
    check("rst_flits", 64'(flits_sent_o), 64'd0);
    check("rst_pkts", 64'(pkts_sent_o), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Single-flit packet: HEADTAIL on VC0 two cycles after accept
    send_pkt(2, 3, 1, 0, 2, 16'h0, a1);
    @(negedge clk);
    check("single_busy_vcsel", 64'(busy_o), 64'd1);
    while (cyc < a1 + 3) @(negedge clk);
    check("single_busy_drop", 64'(busy_o), 64'd0);
    wait_idle();

    // Four-flit packet on VC1 (pointer advanced)
    send_pkt(1, 0, 4, 1, 2, 16'h00A0, a1);
    wait_idle();

    // Back-to-back len=2 packets: VC2 then VC3, one idle cycle between
    send_pkt(3, 1, 2, 2, 2, 16'h00B0, a1);
    send_pkt(0, 2, 2, 3, 2, 16'h00C0, a2);
    check("b2b_accept_gap", 64'(a2), 64'(a1 + 4));
    wait_idle();

    // Flow-control stall mid-body on VC0 (pointer wrapped)
    send_pkt(1, 1, 5, 0, -1, 16'h00D0, a1);
    wait_body();
    @(posedge clk);
    #1;
    is_on_off_i = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_no_valid", 64'(is_valid_o), 64'd0);
      check("stall_no_pld_ready", 64'(pld_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    is_on_off_i = 4'b1111;
    @(negedge clk);
    check("stall_resume_valid", 64'(is_valid_o), 64'd1);
    check("stall_resume_pld_ready", 64'(pld_ready_o), 64'd1);
    wait_idle();

    // Length 0 is a single HEADTAIL flit, VC1
    send_pkt(0, 1, 0, 1, 2, 16'h0, a1);
    wait_idle();

    // No VC allocatable for 5 cycles, then only VC1 (search wraps from pointer 2)
    is_allocatable_i = 4'b0000;
    send_pkt(2, 2, 2, 1, 6, 16'h00E0, a1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("vcsel_busy", 64'(busy_o), 64'd1);
      check("vcsel_no_valid", 64'(is_valid_o), 64'd0);
    end
    is_allocatable_i = 4'b0010;
    wait_idle();
    is_allocatable_i = 4'b1111;

    // Reset mid-body of a len=6 packet on VC2
    send_pkt(3, 3, 6, 2, 2, 16'h00F0, a1);
    wait_body();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    pld_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(is_valid_o), 64'd0);
    check("midrst_pkt_ready", 64'(pkt_ready_o), 64'd1);
    check("midrst_busy", 64'(busy_o), 64'd0);
`ifdef LOCAL_INJECTOR_STATS_EN
    check("midrst_flits", 64'(flits_sent_o), 64'd0);
    check("midrst_pkts", 64'(pkts_sent_o), 64'd0);
    check("midrst_stalls", 64'(stall_cycles_o), 64'd0);
`endif
    @(posedge clk);
    #1;
    send_pkt(1, 2, 1, 0, 2, 16'h0, a1);
    wait_idle();

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
